// File: rtl/zap_wb_ram_responder.sv
// Wishbone B3 word-addressed RAM slave with programmable wait states and registered responses.
// Define ZAP_WB_RAM_BURST_EN to add incrementing-burst support (cti=010, bte=00).
module zap_wb_ram_responder #(
    parameter int unsigned DEPTH       = 32'd1024,
    parameter int unsigned WAIT_STATES = 32'd1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [2:0]  i_wb_cti,
    input  logic [1:0]  i_wb_bte,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    localparam int         AW = $clog2(DEPTH);
    localparam logic [3:0] WS = WAIT_STATES[3:0];

    typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [29:0] req_idx;
    logic        req_we;
    logic [3:0]  req_sel;
    logic [31:0] req_dat;
    logic        lat_en, resp, adv;
    logic        ack_nxt, err_nxt;
    logic [31:0] dat_nxt;
    logic [29:0] cls_idx, nxt_idx;
    logic        cls_we;
    logic        wr_fire;
    logic [31:0] wr_dat;
    logic [3:0]  wr_sel;
    logic [31:0] mem [DEPTH];

`ifdef ZAP_WB_RAM_BURST_EN
    logic req_burst;
    logic unused_ok;
    assign unused_ok = ^i_wb_adr[1:0];
`else
    logic unused_ok;
    assign unused_ok = ^{i_wb_adr[1:0], i_wb_cti, i_wb_bte};
`endif

    function automatic logic in_range(input logic [29:0] idx);
        return ({2'b00, idx} < DEPTH);
    endfunction

    // A zero-wait-state request is answered straight from IDLE, before the request is latched
    assign cls_idx = (state == IDLE) ? i_wb_adr[31:2] : req_idx;
    assign cls_we  = (state == IDLE) ? i_wb_we : req_we;
    assign nxt_idx = req_idx + 30'd1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lat_en    = 1'b0;
        resp      = 1'b0;
        adv       = 1'b0;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
        dat_nxt   = 32'd0;
        case (state)
            IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    lat_en  = 1'b1;
                    cnt_nxt = WS;
                    if (WS != 4'd0) begin
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = ACK;
                        resp      = 1'b1;
                    end
                end
            end
            WAIT: begin
                // Abort wins over a counter that expires in the same cycle
                if (!i_wb_cyc) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (i_wb_stb) begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nxt = ACK;
                        resp      = 1'b1;
                    end
                end
            end
            ACK: begin
                state_nxt = IDLE;
`ifdef ZAP_WB_RAM_BURST_EN
                if (req_burst && o_wb_ack && i_wb_cyc) begin
                    state_nxt = BURST;
                    adv       = i_wb_stb;
                end
`endif
            end
            BURST: begin
`ifdef ZAP_WB_RAM_BURST_EN
                // Each sampled strobe registers the next beat's response for the following cycle
                if (!i_wb_cyc || o_wb_err || (o_wb_ack && i_wb_cti == 3'b111)) begin
                    state_nxt = IDLE;
                end else begin
                    adv = i_wb_stb;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase

        if (resp) begin
            if (in_range(cls_idx)) begin
                ack_nxt = 1'b1;
                if (!cls_we) dat_nxt = mem[cls_idx[AW-1:0]];
            end else begin
                err_nxt = 1'b1;
            end
        end
        if (adv) begin
            if (in_range(nxt_idx)) begin
                ack_nxt = 1'b1;
                if (!req_we) dat_nxt = mem[nxt_idx[AW-1:0]];
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        wr_fire = 1'b0;
        wr_dat  = req_dat;
        wr_sel  = req_sel;
        if (o_wb_ack && req_we) begin
            if (state == ACK) begin
                wr_fire = 1'b1;
            end else if (state == BURST && i_wb_cyc && i_wb_stb) begin
                wr_fire = 1'b1;
                wr_dat  = i_wb_dat;
                wr_sel  = i_wb_sel;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            req_idx  <= 30'd0;
            req_we   <= 1'b0;
            req_sel  <= 4'd0;
            req_dat  <= 32'd0;
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= 32'd0;
`ifdef ZAP_WB_RAM_BURST_EN
            req_burst <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            o_wb_ack <= ack_nxt;
            o_wb_err <= err_nxt;
            o_wb_dat <= dat_nxt;
            if (lat_en) begin
                req_idx <= i_wb_adr[31:2];
                req_we  <= i_wb_we;
                req_sel <= i_wb_sel;
                req_dat <= i_wb_dat;
`ifdef ZAP_WB_RAM_BURST_EN
                req_burst <= (i_wb_cti == 3'b010) && (i_wb_bte == 2'b00);
`endif
            end else if (adv) begin
                req_idx <= nxt_idx;
            end
        end
    end

    // Storage is never reset; a reset only blocks the write of the cycle it lands in
    always_ff @(posedge i_clk) begin
        if (wr_fire && !i_reset) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_sel[b]) mem[req_idx[AW-1:0]][8*b +: 8] <= wr_dat[8*b +: 8];
            end
        end
    end

endmodule
